// File: rtl/div_iter_pkg.sv
// Shared types and constants for the iterative divider.
// State encoding, datapath width and divide-by-zero quotient.
package div_iter_pkg;

    localparam int DATA_W = 32;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring iteration: shift, trial subtract, quotient bit.
// The quotient bit is shifted into the LSB of the dividend register.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   prem_i,
    input  logic [DATA_W-1:0] dvd_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W:0]   prem_o,
    output logic [DATA_W-1:0] dvd_o
);

    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] diff;
    logic              ge;

    // Shift in the next dividend MSB and restore on a negative difference.
    always_comb begin
        shifted = {prem_i, dvd_i[DATA_W-1]};
        diff    = shifted - {2'b00, dvs_i};
        ge      = ~diff[DATA_W+1];
        prem_o  = ge ? diff[DATA_W:0] : shifted[DATA_W:0];
        dvd_o   = {dvd_i[DATA_W-2:0], ge};
    end

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned 32-bit divider for the execute stage.
// Magnitudes are divided, signs are applied on the way into result.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int DATA_W = div_iter_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              div_en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sign_flag,
    input  logic              rem_flag,
    input  logic              flush,
    output logic              stallreq_for_div,
    output logic [DATA_W-1:0] result,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W);

    div_state_e        state;
    div_state_e        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   prem;
    logic [DATA_W:0]   prem_nxt;
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dvd_nxt;
    logic [DATA_W-1:0] dvs;
    logic              rem_sel;
    logic              q_neg;
    logic              r_neg;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              start;
    logic [DATA_W-1:0] q_fin;
    logic [DATA_W-1:0] r_fin;

    assign a_neg = sign_flag & a[DATA_W-1];
    assign b_neg = sign_flag & b[DATA_W-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    assign start = (state == DIV_IDLE) & div_en & ~flush;
    assign done  = (state == DIV_DONE);

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .prem_i (prem),
        .dvd_i  (dvd),
        .dvs_i  (dvs),
        .prem_o (prem_nxt),
        .dvd_o  (dvd_nxt)
    );

    assign q_fin = q_neg ? -dvd_nxt : dvd_nxt;
    assign r_fin = r_neg ? -prem_nxt[DATA_W-1:0]
                         : prem_nxt[DATA_W-1:0];

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stall request; flush overrides every transition.
    always_comb begin
        state_nxt        = state;
        stallreq_for_div = start | (state == DIV_BUSY);
        if (flush) begin
            state_nxt = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (div_en) begin
                        state_nxt = (b == '0) ? DIV_DONE : DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    if (cnt == '0) begin
                        state_nxt = DIV_DONE;
                    end
                end
                DIV_DONE: state_nxt = DIV_IDLE;
                default:  state_nxt = DIV_IDLE;
            endcase
        end
    end

    // Operand capture, iteration and result load.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            prem    <= '0;
            dvd     <= '0;
            dvs     <= '0;
            rem_sel <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            result  <= '0;
        end else if (!flush) begin
            if (start) begin
                if (b == '0) begin
                    result <= rem_flag ? a : DATA_W'(DIV0_QUOT);
                end else begin
                    dvd     <= a_mag;
                    dvs     <= b_mag;
                    prem    <= '0;
                    cnt     <= CNT_W'(DATA_W - 1);
                    rem_sel <= rem_flag;
                    q_neg   <= a_neg ^ b_neg;
                    r_neg   <= a_neg;
                end
            end else if (state == DIV_BUSY) begin
                prem <= prem_nxt;
                dvd  <= dvd_nxt;
                cnt  <= cnt - 1'b1;
                if (cnt == '0) begin
                    result <= rem_sel ? r_fin : q_fin;
                end
            end
        end
    end

endmodule
